iir_stim_gen: RTL and testbench

- Sample-stream source that drives the dv/data input interface of the cascaded-SOS IIR filter chain. It is the producing end of the same single-strobe valid/data protocol the filter consumes.
- Emits a programmed number of 18-bit signed samples at a fixed strobe rate. Waveforms: impulse, step, square or pseudo-random noise.
- Used for in-system characterisation and as the bench driver for the filter.

---
 rtl/iir_stim_gen_if.sv | 20 ++
 rtl/iir_stim_gen.sv | 99 +++++++++
 tb/tb_iir_stim_gen.sv | 139 +++++++++++++
 3 files changed

// File: rtl/iir_stim_gen_if.sv
// iir_stim_gen_if: control and sample-stream bundle of iir_stim_gen; IIR_STIM_LAST_EN adds last_out.
interface iir_stim_gen_if;
   logic               start;
   logic               abort;
   logic [1:0]         mode;
   logic signed [17:0] amp;
   logic [15:0]        count;
   logic               busy;
   logic               done;
   logic               dv_out;
   logic signed [17:0] d_out;
`ifdef IIR_STIM_LAST_EN
   logic               last_out;
   modport master (input start, abort, mode, amp, count, output busy, done, dv_out, d_out, last_out);
   modport slave (output start, abort, mode, amp, count, input busy, done, dv_out, d_out, last_out);
`else
   modport master (input start, abort, mode, amp, count, output busy, done, dv_out, d_out);
   modport slave (output start, abort, mode, amp, count, input busy, done, dv_out, d_out);
`endif
endinterface

// File: rtl/iir_stim_gen.sv
// iir_stim_gen: burst sample source (impulse/step/square/noise) for the IIR chain; IIR_STIM_LAST_EN adds last_out.
module iir_stim_gen #(
   parameter int unsigned RATE_DIV  = 16,
   parameter int unsigned SQ_HALF   = 8,
   parameter logic [22:0] LFSR_SEED = 23'h000001
) (
   input logic            clk,
   input logic            resetn,
   iir_stim_gen_if.master sg
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   localparam int SW = $clog2(SQ_HALF + 1);
   localparam logic [16:0]   RATE_LD = 17'(RATE_DIV - 1);
   localparam logic [SW-1:0] SQ_LD   = SW'(SQ_HALF - 1);
   state_t             state_q;
   logic [1:0]         mode_q;
   logic signed [17:0] amp_q, d_q, neg_amp, sample;
   logic [15:0]        cnt_q, idx_q;
   logic [16:0]        rate_q;
   logic [SW-1:0]      sq_q;
   logic [22:0]        lfsr_q;
   logic               phase_q, busy_q, done_q, dv_q, strobe, last;
`ifdef IIR_STIM_LAST_EN
   logic               last_q;
   assign sg.last_out = last_q;
`endif
   assign sg.busy   = busy_q;
   assign sg.done   = done_q;
   assign sg.dv_out = dv_q;
   assign sg.d_out  = d_q;
   always_comb begin
      neg_amp = (amp_q == 18'sh20000) ? 18'sh1ffff : -amp_q;
      sample  = mode_q == 2'd0 ? ((idx_q == '0) ? amp_q : '0)
              : mode_q == 2'd1 ? amp_q
              : mode_q == 2'd2 ? (phase_q ? neg_amp : amp_q)
              : $signed(lfsr_q[17:0]);
      strobe  = state_q == RUN && !sg.abort && rate_q == '0;
      last    = idx_q == cnt_q - 16'd1;
   end
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= IDLE;
         mode_q  <= '0;
         amp_q   <= '0;
         cnt_q   <= '0;
         idx_q   <= '0;
         rate_q  <= '0;
         sq_q    <= '0;
         phase_q <= 1'b0;
         lfsr_q  <= LFSR_SEED;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         dv_q    <= 1'b0;
         d_q     <= '0;
`ifdef IIR_STIM_LAST_EN
         last_q  <= 1'b0;
`endif
      end else begin
         dv_q   <= 1'b0;
         done_q <= 1'b0;
`ifdef IIR_STIM_LAST_EN
         last_q <= strobe && last;
`endif
         case (state_q)
            IDLE: if (sg.start && !sg.abort && sg.count != '0) begin
               state_q <= RUN;
               mode_q  <= sg.mode;
               amp_q   <= sg.amp;
               cnt_q   <= sg.count;
               idx_q   <= '0;
               rate_q  <= '0;
               sq_q    <= '0;
               phase_q <= 1'b0;
            end
            RUN: if (sg.abort) begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end else if (strobe) begin
               dv_q    <= 1'b1;
               d_q     <= sample;
               busy_q  <= 1'b1;
               rate_q  <= RATE_LD;
               idx_q   <= idx_q + 16'd1;
               sq_q    <= (sq_q == SQ_LD) ? '0 : sq_q + 1'b1;
               phase_q <= phase_q ^ (sq_q == SQ_LD);
               if (mode_q == 2'd3) lfsr_q <= {lfsr_q[21:0], lfsr_q[22] ^ lfsr_q[17]};
               if (last) state_q <= DONE;
            end else begin
               rate_q <= rate_q - 17'd1;
            end
            default: begin
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_iir_stim_gen.sv
// tb_iir_stim_gen: directed checks of iir_stim_gen at RATE_DIV=4/SQ_HALF=2 and RATE_DIV=1.
module tb_iir_stim_gen;
   logic clk = 1'b0;
   logic resetn = 1'b0;
   int n_cmp = 0;
   int n_err = 0;
   logic signed [17:0] smp[$];
   int strb_cyc[$];
   int done_cyc, n_done, busy_first, busy_last, n;
   iir_stim_gen_if sa();
   iir_stim_gen_if sb();
   iir_stim_gen #(.RATE_DIV(4), .SQ_HALF(2)) dut_a (.clk(clk), .resetn(resetn), .sg(sa));
   iir_stim_gen #(.RATE_DIV(1)) dut_b (.clk(clk), .resetn(resetn), .sg(sb));
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   function automatic logic [31:0] smp_at(input int i);
      return i < smp.size() ? 32'(smp[i]) : 'x;
   endfunction
   function automatic logic [31:0] cyc_at(input int i);
      return i < strb_cyc.size() ? 32'(strb_cyc[i]) : 'x;
   endfunction
   task automatic burst(input logic [1:0] m, input logic signed [17:0] a, input logic [15:0] c,
                        input int cycles, input int poke, input logic ab);
      smp.delete();
      strb_cyc.delete();
      done_cyc = -1; n_done = 0; busy_first = -1; busy_last = -1;
      sa.mode = m; sa.amp = a; sa.count = c; sa.start = 1'b1; sa.abort = ab;
      @(negedge clk);
      sa.start = 1'b0; sa.abort = 1'b0;
      for (int i = 1; i <= cycles; i++) begin
         @(negedge clk);
         if (sa.dv_out) begin smp.push_back(sa.d_out); strb_cyc.push_back(i); end
         if (sa.done) begin n_done++; if (done_cyc < 0) done_cyc = i; end
         if (sa.busy) begin busy_last = i; if (busy_first < 0) busy_first = i; end
         sa.start = (i == poke);
         if (i == poke) begin sa.count = 16'd1; sa.amp = 18'sd999; end
      end
      sa.start = 1'b0;
   endtask
   task automatic do_reset();
      resetn = 1'b0;
      @(negedge clk);
      @(negedge clk);
      resetn = 1'b1;
   endtask
   initial begin
      sa.start = 0; sa.abort = 0; sa.mode = 0; sa.amp = 0; sa.count = 0;
      sb.start = 0; sb.abort = 0; sb.mode = 0; sb.amp = 0; sb.count = 0;
      do_reset();
      check("rst_busy", sa.busy, 0);
      check("rst_done", sa.done, 0);
      check("rst_dv", sa.dv_out, 0);
      check("rst_dout", 32'(sa.d_out), 0);
      burst(2'd0, 18'sh10000, 16'd5, 20, 0, 1'b0);
      check("imp_n", strb_cyc.size(), 5);
      for (int i = 0; i < 5; i++) begin
         check($sformatf("imp_cyc%0d", i), cyc_at(i), 32'(1 + 4 * i));
         check($sformatf("imp_val%0d", i), smp_at(i), (i == 0) ? 32'h10000 : 32'h0);
      end
      check("imp_done_cyc", done_cyc, 18);
      check("imp_done_n", n_done, 1);
      check("imp_busy_first", busy_first, 1);
      check("imp_busy_last", busy_last, 17);
      burst(2'd2, -18'sd131072, 16'd6, 26, 0, 1'b0);
      check("sq_n", smp.size(), 6);
      for (int i = 0; i < 6; i++)
         check($sformatf("sq_val%0d", i), smp_at(i), (i == 2 || i == 3) ? 32'd131071 : -32'sd131072);
      check("sq_hold", 32'(sa.d_out), -32'sd131072);
      do_reset();
      burst(2'd3, 18'sd0, 16'd3, 14, 0, 1'b0);
      check("nz1_n", smp.size(), 3);
      for (int i = 0; i < 3; i++) check($sformatf("nz1_val%0d", i), smp_at(i), 32'(1 << i));
      burst(2'd3, 18'sd0, 16'd3, 14, 0, 1'b0);
      for (int i = 0; i < 3; i++) check($sformatf("nz2_val%0d", i), smp_at(i), 32'(8 << i));
      sa.mode = 2'd1; sa.amp = 18'sd1234; sa.count = 16'd10; sa.start = 1'b1;
      @(negedge clk);
      sa.start = 1'b0;
      n = 0; n_done = 0;
      for (int i = 1; i <= 40 && n < 3; i++) begin
         @(negedge clk);
         if (sa.dv_out) n++;
         if (sa.done) n_done++;
      end
      check("ab_pre_strobes", n, 3);
      check("ab_pre_val", 32'(sa.d_out), 32'd1234);
      sa.abort = 1'b1;
      @(negedge clk);
      sa.abort = 1'b0;
      check("ab_busy", sa.busy, 0);
      check("ab_dv", sa.dv_out, 0);
      check("ab_no_done", n_done, 0);
      burst(2'd1, 18'sd77, 16'd2, 10, 0, 1'b0);
      check("ab_new_n", strb_cyc.size(), 2);
      check("ab_new_cyc0", cyc_at(0), 1);
      check("ab_new_cyc1", cyc_at(1), 5);
      check("ab_new_val", smp_at(0), 32'd77);
      check("ab_new_done", n_done, 1);
      burst(2'd1, 18'sd5, 16'd0, 10, 0, 1'b0);
      check("c0_n", smp.size(), 0);
      check("c0_done", n_done, 0);
      burst(2'd1, 18'sd300, 16'd3, 14, 3, 1'b0);
      check("rs_n", smp.size(), 3);
      check("rs_val2", smp_at(2), 32'd300);
      check("rs_done_cyc", done_cyc, 10);
      burst(2'd1, 18'sd5, 16'd2, 12, 0, 1'b1);
      check("sa_n", smp.size(), 0);
      check("sa_busy", busy_first, -1);
      burst(2'd1, 18'sd500, 16'd10, 5, 0, 1'b0);
      check("mr_dv_pre", sa.dv_out, 1);
      check("mr_val_pre", 32'(sa.d_out), 32'd500);
      resetn = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      check("mr_busy", sa.busy, 0);
      check("mr_dv", sa.dv_out, 0);
      check("mr_dout", 32'(sa.d_out), 0);
      check("mr_done", sa.done, 0);
      sb.mode = 2'd1; sb.amp = 18'sd100; sb.count = 16'd4; sb.start = 1'b1;
      @(negedge clk);
      sb.start = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         @(negedge clk);
         check($sformatf("b2b_dv%0d", i), sb.dv_out, 32'(i >= 1 && i <= 4));
         if (i <= 4) check($sformatf("b2b_val%0d", i), 32'(sb.d_out), 32'd100);
         check($sformatf("b2b_done%0d", i), sb.done, 32'(i == 5));
`ifdef IIR_STIM_LAST_EN
         check($sformatf("b2b_last%0d", i), sb.last_out, 32'(i == 4));
`endif
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
